booth_mul_seq: RTL

BOOTH_MUL_SEQ -- requirements
Module: booth_mul_seq

---
 rtl/booth_mul_pkg.sv | 38 +++
 rtl/booth_r4_enc.sv | 30 +++
 rtl/booth_mul_seq.sv | 117 +++++++++++
 3 files changed

// File: rtl/booth_mul_pkg.sv
// Shared types and helpers for the radix-4 Booth sequential multiplier.
package booth_mul_pkg;

  localparam int unsigned BOOTH_WIDTH_MIN = 8;
  localparam int unsigned BOOTH_WIDTH_MAX = 64;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } booth_state_e;

  typedef enum logic [2:0] {
    DIG_ZERO = 3'd0,
    DIG_P1   = 3'd1,
    DIG_P2   = 3'd2,
    DIG_M1   = 3'd3,
    DIG_M2   = 3'd4
  } booth_digit_e;

  function automatic bit booth_width_legal(input int unsigned w);
    return (w >= BOOTH_WIDTH_MIN) && (w <= BOOTH_WIDTH_MAX) && ((w % 2) == 0);
  endfunction

  // Window is {b(2i+1), b(2i), b(2i-1)}.
  function automatic booth_digit_e booth_decode(input logic [2:0] win);
    booth_digit_e d;
    case (win)
      3'b001, 3'b010: d = DIG_P1;
      3'b011:         d = DIG_P2;
      3'b100:         d = DIG_M2;
      3'b101, 3'b110: d = DIG_M1;
      default:        d = DIG_ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_r4_enc.sv
// Radix-4 Booth partial-product generator: window + multiplicand -> digit*multiplicand.
module booth_r4_enc
  import booth_mul_pkg::*;
#(
  parameter int unsigned PW = 64
) (
  input  logic [2:0]    i_window,
  input  logic [PW-1:0] i_mcand,
  output logic [PW-1:0] o_pp
);

  booth_digit_e  w_digit;
  logic [PW-1:0] w_mag;

  always_comb begin
    w_digit = booth_decode(i_window);
    w_mag   = '0;
    case (w_digit)
      DIG_P1, DIG_M1: w_mag = i_mcand;
      DIG_P2, DIG_M2: w_mag = {i_mcand[PW-2:0], 1'b0};
      default:        w_mag = '0;
    endcase
    if ((w_digit == DIG_M1) || (w_digit == DIG_M2)) begin
      o_pp = (~w_mag) + PW'(1);
    end else begin
      o_pp = w_mag;
    end
  end

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier, one digit per cycle, valid/ready on both sides.
// Optional BOOTH_MUL_EARLY_TERM_EN: stop as soon as the remaining multiplier digits are all zero.
module booth_mul_seq
  import booth_mul_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     src1,
  input  logic [WIDTH-1:0]     src2,
  input  logic                 mul_signed,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned PW    = 2 * WIDTH;
  localparam int unsigned EW    = WIDTH + 2;
  localparam int unsigned STEPS = WIDTH / 2 + 1;
  localparam int unsigned CNT_W = $clog2(STEPS + 1);
  localparam bit          WIDTH_OK = booth_width_legal(WIDTH);

  generate
    if (!WIDTH_OK) begin : g_width_check
      $error("booth_mul_seq: WIDTH must be even and within 8..64");
    end
  endgenerate

  booth_state_e     r_state;
  logic [EW:0]      r_mplier;
  logic [PW-1:0]    r_mcand;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_result;
  logic [CNT_W-1:0] r_step;

  logic             w_accept;
  logic             w_last;
  logic             w_early;
  logic [EW:0]      w_s1_ext;
  logic [PW-1:0]    w_s2_ext;
  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_sum;

  assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
  assign out_valid = (r_state == ST_DONE);
  assign result    = r_result;
  assign w_accept  = in_valid && in_ready;

  // Multiplier carries the b(-1) overlap bit at position 0.
  assign w_s1_ext = {{2{mul_signed & src1[WIDTH-1]}}, src1, 1'b0};
  assign w_s2_ext = {{WIDTH{mul_signed & src2[WIDTH-1]}}, src2};

  assign w_last = (r_step == CNT_W'(STEPS - 1));
  assign w_sum  = r_acc + w_pp;

`ifdef BOOTH_MUL_EARLY_TERM_EN
  // Shifts replicate the top bit, so a uniform register means every remaining digit is zero.
  assign w_early = (r_mplier == '0) || (r_mplier == '1);
`else
  assign w_early = 1'b0;
`endif

  booth_r4_enc #(
    .PW(PW)
  ) u_enc (
    .i_window(r_mplier[2:0]),
    .i_mcand (r_mcand),
    .o_pp    (w_pp)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_mplier <= '0;
      r_mcand  <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_step   <= '0;
    end else if (w_accept) begin
      r_state  <= ST_CALC;
      r_mplier <= w_s1_ext;
      r_mcand  <= w_s2_ext;
      r_acc    <= '0;
      r_step   <= '0;
    end else begin
      case (r_state)
        ST_CALC: begin
          if (w_early) begin
            r_result <= r_acc;
            r_state  <= ST_DONE;
          end else begin
            r_acc    <= w_sum;
            r_mplier <= {{2{r_mplier[EW]}}, r_mplier[EW:2]};
            r_mcand  <= {r_mcand[PW-3:0], 2'b00};
            r_step   <= r_step + CNT_W'(1);
            if (w_last) begin
              r_result <= w_sum;
              r_state  <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
